// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: per-frame Pong sequencer (sync vsync/buttons in; ball, paddle, score, state, winner, frame_tick out)
module pong_game_ctrl #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 48,
  parameter int PADDLE_X_GAP = 16,
  parameter int BALL_SIZE    = 8,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 9
) (
  input  logic       i_CLK,
  input  logic       i_RST_n,
  input  logic       i_vSync,
  input  logic       i_start,
  input  logic       i_p1_up,
  input  logic       i_p1_dn,
  input  logic       i_p2_up,
  input  logic       i_p2_dn,
  output logic [9:0] o_ball_x,
  output logic [9:0] o_ball_y,
  output logic [9:0] o_p1_y,
  output logic [9:0] o_p2_y,
  output logic [3:0] o_p1_score,
  output logic [3:0] o_p2_score,
  output logic [1:0] o_state,
  output logic       o_winner,
  output logic       o_frame_tick
);
  typedef enum logic [1:0] {IDLE, SERVE, PLAY, OVER} state_t;
  localparam logic [9:0] BX0  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] BY0  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [9:0] P0   = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] PMAX = 10'(SCREEN_H - PADDLE_H);
  localparam logic [9:0] XMAX = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0] YMAX = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] PL_R = 10'(PADDLE_X_GAP + PADDLE_W);
  localparam logic [9:0] PR_X = 10'(SCREEN_W - PADDLE_X_GAP - PADDLE_W);
  localparam logic [9:0] BS   = 10'(BALL_SIZE);
  localparam logic [9:0] BSP  = 10'(BALL_SPEED);
  localparam logic [9:0] PSP  = 10'(PADDLE_SPEED);
  localparam logic [9:0] PH   = 10'(PADDLE_H);
  localparam logic [7:0] SF1  = 8'(SERVE_FRAMES - 1);
  localparam logic [3:0] WIN  = 4'(WIN_SCORE);
  logic [2:0] r_vs;
  logic [4:0] r_btn1, r_btn2;
  logic       r_tick, r_dx, r_dy, r_winner;
  state_t     r_state, w_state;
  logic [9:0] r_ball_x, r_ball_y, r_p1_y, r_p2_y;
  logic [9:0] w_ball_x, w_ball_y, w_p1_y, w_p2_y;
  logic [3:0] r_p1_score, r_p2_score, w_p1_score, w_p2_score;
  logic [7:0] r_cnt, w_cnt;
  logic       w_dx, w_dy, w_winner;
  logic       w_tick, w_start, w_ov1, w_ov2, w_sc1, w_sc2;
  function automatic logic [9:0] f_pad(input logic [9:0] y, input logic up, input logic dn);
    return (up & ~dn) ? ((y < PSP) ? '0 : y - PSP) :
           (dn & ~up) ? ((y > PMAX - PSP) ? PMAX : y + PSP) : y;
  endfunction
  assign w_tick  = r_vs[1] & ~r_vs[2];
  assign w_start = r_btn2[4];
  assign w_ov1   = (r_ball_y + BS > r_p1_y) && (r_ball_y < r_p1_y + PH);
  assign w_ov2   = (r_ball_y + BS > r_p2_y) && (r_ball_y < r_p2_y + PH);
  assign w_sc1   = r_dx && (r_ball_x + BSP > XMAX);
  assign w_sc2   = !r_dx && (r_ball_x < BSP);
  always_comb begin
    w_state    = r_state;
    w_ball_x   = r_ball_x;
    w_ball_y   = r_ball_y;
    w_dx       = r_dx;
    w_dy       = r_dy;
    w_p1_y     = r_p1_y;
    w_p2_y     = r_p2_y;
    w_p1_score = r_p1_score;
    w_p2_score = r_p2_score;
    w_winner   = r_winner;
    w_cnt      = r_cnt;
    if (r_state == SERVE || r_state == PLAY) begin
      w_p1_y = f_pad(r_p1_y, r_btn2[3], r_btn2[2]);
      w_p2_y = f_pad(r_p2_y, r_btn2[1], r_btn2[0]);
    end
    case (r_state)
      IDLE: begin
        w_ball_x   = BX0;
        w_ball_y   = BY0;
        w_p1_score = '0;
        w_p2_score = '0;
        if (w_start) begin
          w_state = SERVE;
          w_cnt   = '0;
        end
      end
      SERVE: begin
        w_ball_x = BX0;
        w_ball_y = BY0;
        w_cnt    = (r_cnt == SF1) ? '0 : r_cnt + 8'd1;
        w_state  = (r_cnt == SF1) ? PLAY : SERVE;
      end
      PLAY: begin
        if (r_dx) begin
          if (r_ball_x + BS <= PR_X && r_ball_x + BS + BSP > PR_X && w_ov2) begin
            w_ball_x = PR_X - BS;
            w_dx     = 1'b0;
          end else
            w_ball_x = r_ball_x + BSP;
        end else if (r_ball_x >= PL_R && r_ball_x - BSP < PL_R && w_ov1) begin
          w_ball_x = PL_R;
          w_dx     = 1'b1;
        end else
          w_ball_x = r_ball_x - BSP;
        if (!r_dy && r_ball_y < BSP) begin
          w_ball_y = '0;
          w_dy     = 1'b1;
        end else if (r_dy && r_ball_y + BSP > YMAX) begin
          w_ball_y = YMAX;
          w_dy     = 1'b0;
        end else
          w_ball_y = r_dy ? r_ball_y + BSP : r_ball_y - BSP;
        if (w_sc1 || w_sc2) begin
          w_ball_x   = BX0;
          w_ball_y   = BY0;
          w_dx       = w_sc1;
          w_dy       = r_dy;
          w_cnt      = '0;
          w_p1_score = r_p1_score + {3'b0, w_sc1};
          w_p2_score = r_p2_score + {3'b0, w_sc2};
          w_state    = (w_p1_score == WIN || w_p2_score == WIN) ? OVER : SERVE;
          w_winner   = (w_state == OVER) ? w_sc2 : r_winner;
        end
      end
      OVER: begin
        if (w_start) begin
          w_state    = IDLE;
          w_ball_x   = BX0;
          w_ball_y   = BY0;
          w_p1_score = '0;
          w_p2_score = '0;
          w_p1_y     = P0;
          w_p2_y     = P0;
          w_dx       = 1'b1;
          w_dy       = 1'b1;
        end
      end
    endcase
  end
  always_ff @(posedge i_CLK) begin
    if (!i_RST_n) begin
      r_vs       <= 3'b111;
      r_btn1     <= '0;
      r_btn2     <= '0;
      r_tick     <= 1'b0;
      r_state    <= IDLE;
      r_ball_x   <= BX0;
      r_ball_y   <= BY0;
      r_dx       <= 1'b1;
      r_dy       <= 1'b1;
      r_p1_y     <= P0;
      r_p2_y     <= P0;
      r_p1_score <= '0;
      r_p2_score <= '0;
      r_winner   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_vs   <= {r_vs[1:0], i_vSync};
      r_btn1 <= {i_start, i_p1_up, i_p1_dn, i_p2_up, i_p2_dn};
      r_btn2 <= r_btn1;
      r_tick <= w_tick;
      if (w_tick) begin
        r_state    <= w_state;
        r_ball_x   <= w_ball_x;
        r_ball_y   <= w_ball_y;
        r_dx       <= w_dx;
        r_dy       <= w_dy;
        r_p1_y     <= w_p1_y;
        r_p2_y     <= w_p2_y;
        r_p1_score <= w_p1_score;
        r_p2_score <= w_p2_score;
        r_winner   <= w_winner;
        r_cnt      <= w_cnt;
      end
    end
  end
  assign o_ball_x     = r_ball_x;
  assign o_ball_y     = r_ball_y;
  assign o_p1_y       = r_p1_y;
  assign o_p2_y       = r_p2_y;
  assign o_p1_score   = r_p1_score;
  assign o_p2_score   = r_p2_score;
  assign o_state      = r_state;
  assign o_winner     = r_winner;
  assign o_frame_tick = r_tick;
endmodule
